// File: rtl/track_pkg.sv
// track_pkg: shared cell encoding, lane count and LFSR step for the obstacle track.
package track_pkg;
   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      OBSTACLE = 2'd1,
      POWERUP  = 2'd2
   } cell_t;
   localparam int NUM_LANES = 3;
   // Taps at bits 15, 13, 12, 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with seed load and advance enable; a zero seed becomes 16'h0001.
module lfsr16
   import track_pkg::*;
#(
   parameter logic [15:0] SEED = 16'h0001
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        en_i,
   output logic [15:0] state_o
);
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   logic [15:0] state_q, state_d;
   always_comb state_d = load_i ? SEED_EFF : en_i ? lfsr_next(state_q) : state_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= SEED_EFF;
      else state_q <= state_d;
   end
   assign state_o = state_q;
endmodule

// File: rtl/obstacle_track.sv
// obstacle_track: three-lane obstacle/powerup field with scroll-driven spawning and collision strobes.
// Define OBSTACLE_POWERUP_EN to let spawned items become powerups.
module obstacle_track
   import track_pkg::*;
#(
   parameter int          NUM_SLOTS = 16,
   parameter int          MIN_GAP   = 2,
   parameter logic [15:0] LFSR_SEED = 16'h0001
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       pulse,
   input  logic                       playing,
   input  logic                       reset_game,
   input  logic [1:0]                 lane,
   input  logic                       jump,
   output logic                       died,
   output logic                       got_powerup,
   output logic [3*NUM_SLOTS*2-1:0]   track_out
);
   localparam int GW = $clog2(MIN_GAP + 2);
   cell_t         track_q [NUM_LANES][NUM_SLOTS];
   cell_t         track_d [NUM_LANES][NUM_SLOTS];
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   lfsr_q;
   logic          scroll, spawn, hit, died_q, died_d;
   cell_t         cur, item;
   assign scroll = pulse & playing;
   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_i   (clk_in),
      .rst_ni  (rst_n_in),
      .load_i  (reset_game),
      .en_i    (scroll),
      .state_o (lfsr_q)
   );
   // Spawn decode looks at the value the LFSR advances to on this edge.
`ifdef OBSTACLE_POWERUP_EN
   logic [4:0] v;
   logic       pw_q, pw_d;
   assign v    = 5'(lfsr_next(lfsr_q));
   assign item = (v[4:2] == 3'b111) ? POWERUP : OBSTACLE;
   assign pw_d = ~reset_game & hit & (cur == POWERUP);
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) pw_q <= 1'b0;
      else pw_q <= pw_d;
   end
   assign got_powerup = pw_q;
`else
   logic [1:0] v;
   assign v           = 2'(lfsr_next(lfsr_q));
   assign item        = OBSTACLE;
   assign got_powerup = 1'b0;
`endif
   assign spawn = (gap_q >= GW'(MIN_GAP)) && (v[1:0] != 2'd3);
   always_comb begin
      cur = EMPTY;
      for (int l = 0; l < NUM_LANES; l++) if (lane == 2'(l)) cur = track_q[l][0];
   end
   assign hit    = playing & ~jump & ((cur == OBSTACLE) | (cur == POWERUP));
   assign died_d = ~reset_game & hit & (cur == OBSTACLE);
   always_comb gap_d = reset_game ? GW'(MIN_GAP) : !scroll ? gap_q : spawn ? '0 :
                       (gap_q >= GW'(MIN_GAP)) ? gap_q : gap_q + 1'b1;
   // A hit without a scroll consumes the cell so it cannot strobe twice.
   always_comb begin
      track_d = track_q;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (scroll) begin
            for (int s = 0; s < NUM_SLOTS - 1; s++) track_d[l][s] = track_q[l][s+1];
            track_d[l][NUM_SLOTS-1] = (spawn && v[1:0] == 2'(l)) ? item : EMPTY;
         end else if (hit && lane == 2'(l)) track_d[l][0] = EMPTY;
         if (reset_game) for (int s = 0; s < NUM_SLOTS; s++) track_d[l][s] = EMPTY;
      end
   end
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int l = 0; l < NUM_LANES; l++)
            for (int s = 0; s < NUM_SLOTS; s++) track_q[l][s] <= EMPTY;
         gap_q  <= GW'(MIN_GAP);
         died_q <= 1'b0;
      end else begin
         track_q <= track_d;
         gap_q   <= gap_d;
         died_q  <= died_d;
      end
   end
   assign died = died_q;
   always_comb begin
      track_out = '0;
      for (int l = 0; l < NUM_LANES; l++)
         for (int s = 0; s < NUM_SLOTS; s++) track_out[(l*NUM_SLOTS+s)*2 +: 2] = track_q[l][s];
   end
endmodule
